// File: rtl/debug_abstract_cmd_encoder_if.sv
// Handshake bundle between the debug module and the abstract-command encoder.
//   cmd_*      : abstract "access register" command, valid/ready.
//   flush      : abort the sequence in flight.
//   inst_*     : encoded instruction words toward the injection path, valid/ready.
//   cmd_done/err: completion pulse and unsupported-regno flag.
// master = debug module side, slave = encoder side.
interface debug_abstract_cmd_encoder_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [15:0] cmd_regno;
    logic        flush;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic        inst_last;
    logic        cmd_done;
    logic        cmd_err;

    modport master (
        output cmd_valid, cmd_write, cmd_regno, flush, inst_ready,
        input  cmd_ready, inst_valid, inst, inst_last, cmd_done, cmd_err
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_regno, flush, inst_ready,
        output cmd_ready, inst_valid, inst, inst_last, cmd_done, cmd_err
    );
endinterface

// File: rtl/debug_abstract_cmd_encoder.sv
// Turns debug "access register" abstract commands into short sequences of RV32
// CSRRW/CSRRS instruction words (optionally followed by EBREAK) for the debug
// instruction-injection path. Data crosses between the debug module and the hart
// through the SCRATCH0 CSR; SCRATCH1 preserves the temp GPR around CSR accesses.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : debug_abstract_cmd_encoder_if.slave (command in, instructions out)
module debug_abstract_cmd_encoder #(
    parameter logic [11:0] SCRATCH0_ADDR = 12'h7B2,
    parameter logic [11:0] SCRATCH1_ADDR = 12'h7B3,
    parameter int unsigned TEMP_REG      = 8,
    parameter bit          APPEND_EBREAK = 1'b1
) (
    input logic                          clk,
    input logic                          rst_n,
    debug_abstract_cmd_encoder_if.slave  bus
);

    localparam logic [6:0]  OpSystem = 7'b1110011;
    localparam logic [2:0]  Fn3Rw    = 3'b001;
    localparam logic [2:0]  Fn3Rs    = 3'b010;
    localparam logic [31:0] Ebreak   = 32'h00100073;
    localparam logic [4:0]  Temp     = 5'(TEMP_REG);
    localparam logic [4:0]  Zero     = 5'd0;
    // Index of the final word: body length minus one, plus the optional EBREAK.
    localparam logic [2:0]  GprLast  = APPEND_EBREAK ? 3'd1 : 3'd0;
    localparam logic [2:0]  CsrLast  = APPEND_EBREAK ? 3'd4 : 3'd3;

    typedef enum logic [1:0] {StIdle, StEmit, StFin} state_e;

    state_e      state_q, state_d;
    logic        write_q, write_d;
    logic        csr_q, csr_d;     // 1 = CSR class, 0 = GPR class
    logic        err_q, err_d;
    logic [11:0] regno_q, regno_d;
    logic [2:0]  step_q, step_d;

    logic [31:0] word;
    logic        last_word;

    function automatic logic [31:0] sys_inst(logic [11:0] csr, logic [4:0] rs1,
                                             logic [2:0] fn3, logic [4:0] rd);
        return {csr, rs1, fn3, rd, OpSystem};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            write_q <= 1'b0;
            csr_q   <= 1'b0;
            err_q   <= 1'b0;
            regno_q <= '0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            csr_q   <= csr_d;
            err_q   <= err_d;
            regno_q <= regno_d;
            step_q  <= step_d;
        end
    end

    // Word selection for the current step.
    always_comb begin
        word = Ebreak;
        if (!csr_q) begin
            if (step_q == 3'd0) begin
                word = write_q ? sys_inst(SCRATCH0_ADDR, Zero, Fn3Rs, regno_q[4:0])
                               : sys_inst(SCRATCH0_ADDR, regno_q[4:0], Fn3Rw, Zero);
            end
        end else begin
            case (step_q)
                3'd0: word = sys_inst(SCRATCH1_ADDR, Temp, Fn3Rw, Zero);
                3'd1: word = write_q ? sys_inst(SCRATCH0_ADDR, Zero, Fn3Rs, Temp)
                                     : sys_inst(regno_q, Zero, Fn3Rs, Temp);
                3'd2: word = write_q ? sys_inst(regno_q, Temp, Fn3Rw, Zero)
                                     : sys_inst(SCRATCH0_ADDR, Temp, Fn3Rw, Zero);
                3'd3: word = sys_inst(SCRATCH1_ADDR, Zero, Fn3Rs, Temp);
                default: word = Ebreak;
            endcase
        end
    end

    assign last_word = (step_q == (csr_q ? CsrLast : GprLast));

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        csr_d   = csr_q;
        err_d   = err_q;
        regno_d = regno_q;
        step_d  = step_q;

        unique case (state_q)
            StIdle: begin
                if (bus.cmd_valid) begin
                    write_d = bus.cmd_write;
                    regno_d = bus.cmd_regno[11:0];
                    step_d  = 3'd0;
                    if (bus.cmd_regno[15:5] == 11'h080) begin
                        csr_d   = 1'b0;
                        err_d   = 1'b0;
                        state_d = StEmit;
                    end else if (bus.cmd_regno[15:12] == 4'h0) begin
                        csr_d   = 1'b1;
                        err_d   = 1'b0;
                        state_d = StEmit;
                    end else begin
                        csr_d   = 1'b0;
                        err_d   = 1'b1;
                        state_d = StFin;
                    end
                end
            end
            StEmit: begin
                // flush wins over a simultaneous handshake
                if (bus.flush) begin
                    state_d = StIdle;
                end else if (bus.inst_ready) begin
                    if (last_word) begin
                        state_d = StFin;
                    end else begin
                        step_d = step_q + 3'd1;
                    end
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        bus.cmd_ready  = (state_q == StIdle);
        bus.inst_valid = (state_q == StEmit);
        bus.inst       = (state_q == StEmit) ? word : 32'h0;
        bus.inst_last  = (state_q == StEmit) && last_word;
        // A flush landing on the FIN cycle suppresses completion.
        bus.cmd_done   = (state_q == StFin) && !bus.flush;
        bus.cmd_err    = (state_q == StFin) && !bus.flush && err_q;
    end

endmodule

// File: tb/tb_debug_abstract_cmd_encoder.sv
module tb_debug_abstract_cmd_encoder;

    localparam logic [31:0] EBRK = 32'h00100073;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    debug_abstract_cmd_encoder_if bus();

    debug_abstract_cmd_encoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] inst;
        logic        last;
        int          due;
    } exp_inst_t;

    typedef struct {
        logic err;
        int   due;
    } exp_done_t;

    exp_inst_t inst_q[$];
    exp_done_t done_q[$];

    int checks    = 0;
    int failures  = 0;
    int cyc       = 0;
    int hs_count  = 0;
    bit bp_mode   = 1'b0;
    int bp_cnt    = 0;
    bit prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
        chk({tag, "_inst_valid"}, 32'(bus.inst_valid), 32'd0);
        chk({tag, "_inst"}, bus.inst, 32'd0);
        chk({tag, "_inst_last"}, 32'(bus.inst_last), 32'd0);
        chk({tag, "_cmd_done"}, 32'(bus.cmd_done), 32'd0);
        chk({tag, "_cmd_err"}, 32'(bus.cmd_err), 32'd0);
    endtask

    task automatic push_inst(input logic [31:0] w, input logic last, input int due);
        exp_inst_t e;
        e.inst = w;
        e.last = last;
        e.due  = due;
        inst_q.push_back(e);
    endtask

    task automatic push_done(input logic err, input int due);
        exp_done_t e;
        e.err = err;
        e.due = due;
        done_q.push_back(e);
    endtask

    // Offer a command; acc is the cycle in which the first word must appear.
    task automatic send(input logic wr, input logic [15:0] rg, output int acc);
        int k = 0;
        @(negedge clk);
        while (!bus.cmd_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) begin
            checks++;
            failures++;
            $display("FAIL cmd_ready_timeout got=0 expected=1");
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_regno = rg;
        acc = cyc + 1;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((inst_q.size() != 0 || done_q.size() != 0) && k < 300) begin
            @(posedge clk);
            k++;
        end
        if (k >= 300) begin
            checks++;
            failures++;
            $display("FAIL sequence_timeout got=%0d/%0d pending expected=0",
                     inst_q.size(), done_q.size());
            inst_q.delete();
            done_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic wait_handshakes(input int target);
        int k = 0;
        while (hs_count < target && k < 100) begin
            @(posedge clk);
            k++;
        end
        if (k >= 100) begin
            checks++;
            failures++;
            $display("FAIL handshake_timeout got=%0d expected=%0d", hs_count, target);
        end
    endtask

    // inst_ready: always high, or 0,0,1 per word under backpressure.
    initial begin
        bus.inst_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (!bp_mode) begin
                bus.inst_ready = 1'b1;
            end else if (!bus.inst_valid) begin
                bus.inst_ready = 1'b0;
                bp_cnt = 0;
            end else if (bp_cnt == 2) begin
                bus.inst_ready = 1'b1;
                bp_cnt = 0;
            end else begin
                bus.inst_ready = 1'b0;
                bp_cnt++;
            end
        end
    end

    // Monitor: compares every presented word and completion pulse against the queues.
    always @(negedge clk) begin
        exp_inst_t e;
        exp_done_t d;
        if (!rst_n) begin
            prev_done = 1'b0;
        end else begin
            if (bus.inst_valid) begin
                if (inst_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_inst got=%h expected=none", bus.inst);
                end else begin
                    e = inst_q[0];
                    chk("inst_word", bus.inst, e.inst);
                    chk("inst_last", 32'(bus.inst_last), 32'(e.last));
                    if (bus.inst_ready) begin
                        if (e.due >= 0) chk("first_word_cycle", 32'(cyc), 32'(e.due));
                        void'(inst_q.pop_front());
                        if (!bus.flush) hs_count++;
                    end
                end
            end
            if (prev_done) chk("done_single_cycle", 32'(bus.cmd_done), 32'd0);
            if (bus.cmd_err && !bus.cmd_done) chk("err_without_done", 32'(bus.cmd_done), 32'd1);
            if (bus.cmd_done) begin
                if (done_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done got=1 expected=0 err=%0b", bus.cmd_err);
                end else begin
                    d = done_q.pop_front();
                    chk("cmd_err", 32'(bus.cmd_err), 32'(d.err));
                    if (d.due >= 0) chk("done_cycle", 32'(cyc), 32'(d.due));
                end
            end
            prev_done = bus.cmd_done;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int hs0;
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_regno = 16'h0;
        bus.flush     = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("after_reset");

        // GPR read x5 with exact timing
        send(1'b0, 16'h1005, acc);
        push_inst(32'h7B229073, 1'b0, acc);
        push_inst(EBRK, 1'b1, -1);
        push_done(1'b0, acc + 2);
        wait_idle();

        // GPR write x10
        send(1'b1, 16'h100A, acc);
        push_inst(32'h7B202573, 1'b0, acc);
        push_inst(EBRK, 1'b1, -1);
        push_done(1'b0, -1);
        wait_idle();

        // CSR read mstatus
        send(1'b0, 16'h0300, acc);
        push_inst(32'h7B341073, 1'b0, acc);
        push_inst(32'h30002473, 1'b0, -1);
        push_inst(32'h7B241073, 1'b0, -1);
        push_inst(32'h7B302473, 1'b0, -1);
        push_inst(EBRK, 1'b1, -1);
        push_done(1'b0, -1);
        wait_idle();

        // CSR write mstatus under backpressure
        bp_mode = 1'b1;
        hs0 = hs_count;
        send(1'b1, 16'h0300, acc);
        push_inst(32'h7B341073, 1'b0, -1);
        push_inst(32'h7B202473, 1'b0, -1);
        push_inst(32'h30041073, 1'b0, -1);
        push_inst(32'h7B302473, 1'b0, -1);
        push_inst(EBRK, 1'b1, -1);
        push_done(1'b0, -1);
        wait_idle();
        chk("bp_handshakes", 32'(hs_count - hs0), 32'd5);
        bp_mode = 1'b0;

        // Unsupported regno
        send(1'b0, 16'h2000, acc);
        push_done(1'b1, acc);
        wait_idle();
        chk("err_ready_after", 32'(bus.cmd_ready), 32'd1);

        // Flush on the third word of a CSR read
        hs0 = hs_count;
        send(1'b0, 16'h0300, acc);
        push_inst(32'h7B341073, 1'b0, acc);
        push_inst(32'h30002473, 1'b0, -1);
        push_inst(32'h7B241073, 1'b0, -1);
        wait_handshakes(hs0 + 2);
        #1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        inst_q.delete();
        @(negedge clk);
        chk("flush_ready", 32'(bus.cmd_ready), 32'd1);
        chk("flush_valid", 32'(bus.inst_valid), 32'd0);
        repeat (3) @(negedge clk);

        // GPR read x1 after the flush
        send(1'b0, 16'h1001, acc);
        push_inst(32'h7B209073, 1'b0, acc);
        push_inst(EBRK, 1'b1, -1);
        push_done(1'b0, acc + 2);
        wait_idle();

        // Reset mid-sequence
        hs0 = hs_count;
        send(1'b0, 16'h0300, acc);
        push_inst(32'h7B341073, 1'b0, acc);
        push_inst(32'h30002473, 1'b0, -1);
        push_inst(32'h7B241073, 1'b0, -1);
        wait_handshakes(hs0 + 2);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        inst_q.delete();
        done_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_ready", 32'(bus.cmd_ready), 32'd1);
        chk("post_reset_valid", 32'(bus.inst_valid), 32'd0);
        repeat (3) @(negedge clk);

        chk("inst_queue_empty", 32'(inst_q.size()), 32'd0);
        chk("done_queue_empty", 32'(done_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/debug_abstract_cmd_encoder.md
Name: debug_abstract_cmd_encoder

Overview:
- Converts RISC-V debug "access register" abstract commands into a short sequence of RV32 SYSTEM-opcode instruction words, plus a terminating EBREAK.
- The words feed the core's debug instruction-injection path, i.e. the fetch side of the decoder.
- This block is the encoding counterpart of the core's opcode/fn3/CSR-address decoding.
- Data moves between the debug module and the hart through a scratch CSR.

Parameters:
- SCRATCH0_ADDR, 12'h7B2, data-transfer scratch CSR (dscratch0).
- SCRATCH1_ADDR, 12'h7B3, save slot for the temp GPR (dscratch1).
- TEMP_REG, 8, GPR index used as the temporary for CSR accesses (s0).
- APPEND_EBREAK, 1, when 1 every non-error sequence ends with EBREAK (32'h00100073).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  abstract command offered
- cmd_ready  out  1  block can accept a command
- cmd_write  in  1  1 = write register from scratch0; 0 = read register into scratch0
- cmd_regno  in  16  debug-spec regno: 0x0000-0x0FFF CSR, 0x1000-0x101F GPR x0-x31
- flush  in  1  abort the current sequence
- inst_valid  out  1  instruction word valid
- inst_ready  in  1  consumer accepts the instruction
- inst  out  32  encoded instruction
- inst_last  out  1  current word is the final word of the sequence
- cmd_done  out  1  one-cycle pulse when the sequence completes
- cmd_err  out  1  one-cycle pulse with cmd_done for an unsupported regno

Behaviour:
- Reset (async, rst_n=0) values: state=IDLE, cmd_ready=1, inst_valid=0, inst=0, inst_last=0, cmd_done=0, cmd_err=0, step counter=0.
- Reset mid-sequence discards everything; no done pulse is produced.

FSM states: IDLE, EMIT, FIN.
- IDLE: cmd_ready=1. On cmd_valid, latch cmd_write and cmd_regno, classify the command, and clear the step counter (3 bits).
  - GPR class (regno[15:5]==11'h080) -> EMIT.
  - CSR class (regno[15:12]==0) -> EMIT.
  - Any other regno -> FIN with the error flag set.
- EMIT: cmd_ready=0 and inst_valid=1. Instruction latency from command acceptance is 1 cycle.
  - On inst_valid&&inst_ready: if inst_last, go to FIN; otherwise increment the step.
  - inst and inst_last are held stable while inst_valid&&!inst_ready.
- FIN: cmd_done=1 for exactly one cycle, and cmd_err=error flag; then return to IDLE. cmd_ready=0 in FIN.
- flush: in EMIT or FIN, go to IDLE next cycle with no cmd_done. flush has priority over a simultaneous handshake. flush in IDLE has no effect.

Encoding:
- Format: inst = {csr[11:0], rs1[4:0], fn3, rd[4:0], 7'b1110011}.
- CSRRW uses fn3 001; CSRRS uses fn3 010.
- r = regno[4:0], T = TEMP_REG, C = regno[11:0], S0/S1 = the scratch addresses.
- GPR read: CSRRW x0,S0,xr.
- GPR write: CSRRS xr,S0,x0. Writing x0 is still emitted (architecturally harmless).
- CSR read: CSRRW x0,S1,xT; CSRRS xT,C,x0; CSRRW x0,S0,xT; CSRRS xT,S1,x0.
- CSR write: CSRRW x0,S1,xT; CSRRS xT,S0,x0; CSRRW x0,C,xT; CSRRS xT,S1,x0.
- If APPEND_EBREAK=1, EBREAK follows. Sequence lengths are then GPR=2 and CSR=5; with APPEND_EBREAK=0 they are GPR=1 and CSR=4.
- inst_last asserts on the final word.
- CSR legality (read-only, nonexistent) is not checked here. The hart traps, and the debug module handles it.
- A command is not accepted in the same cycle as cmd_done. The earliest next acceptance is the cycle after FIN.

Test Plan:
- GPR read x5, inst_ready=1 -> 0x7B229073 (inst_last=0), then 0x00100073 (inst_last=1), then cmd_done=1, cmd_err=0; the first word appears exactly 1 cycle after acceptance.
- GPR write x10 -> 0x7B202573, then 0x00100073; cmd_done pulses once.
- CSR read regno 0x0300 (mstatus) -> 0x7B341073, 0x30002473, 0x7B241073, 0x7B302473, 0x00100073; inst_last only on the 5th word.
- Backpressure: CSR write 0x0300 with inst_ready toggled 0,0,1 per word -> each word is held stable while stalled. Words are 0x7B341073, 0x7B202473, 0x30041073, 0x7B302473, 0x00100073; exactly 5 handshakes.
- regno 0x2000 -> no inst_valid; cmd_done=cmd_err=1 for one cycle, 1 cycle after acceptance; cmd_ready returns high the next cycle.
- flush asserted together with the handshake of word 3 of a CSR read -> IDLE next cycle, no cmd_done. A following GPR read x1 emits 0x7B209073 correctly. Also assert rst_n low mid-sequence -> all outputs return to their reset values immediately.
